ball_sprite_engine: RTL and testbench
=====================================

Name: ball_sprite_engine

Overview:
Moving-ball sprite generator for the Basys3 VGA pong display. It keeps the ball position and velocity, updates them once per frame with wall bounces, and addresses the 16x16 ball bitmap ROM. Each scanned pixel is mapped into a ROM row/column, and the block emits a registered ball_on/ball_rgb pair to the pixel mux. It is the reading side of the 16-row x 16-bit ball bitmap ROM interface: it drives the address and consumes the row data.

Parameters:
H_MAX, 640, visible width in pixels
V_MAX, 480, visible height in pixels
VEL, 2, pixels moved per frame on each axis (1..7)
SERVE_FRAMES, 60, frames held at centre after reset before motion starts
BALL_RGB, 12'hF00, 12-bit colour of lit ball pixels

Ports:
clk  in  1  system clock (pixel-rate enable domain)
reset_n  in  1  synchronous active-low reset
x  in  10  current scan pixel column
y  in  10  current scan pixel row
video_on  in  1  high inside the visible area
refresh_tick  in  1  one-cycle pulse per frame, asserted during vertical blank
pause  in  1  freeze motion while high
rom_addr  out  4  bitmap row address to the ball ROM
rom_data  in  16  bitmap row from the ball ROM (combinational); bit 15 is leftmost
ball_on  out  1  current pipelined pixel is a lit ball pixel
ball_rgb  out  12  BALL_RGB when ball_on, else 12'h000
ball_x  out  10  ball top-left column
ball_y  out  10  ball top-left row

Behaviour:
- Reset (reset_n=0 on a clk edge):
  - ball_x=H_MAX/2-8, ball_y=V_MAX/2-8 (312/232 at defaults).
  - dx=1 (right), dy=1 (down).
  - State=SERVE, serve counter=0.
  - rom_addr=0, ball_on=0, ball_rgb=0, all pipeline registers cleared.
  - Reset mid-frame takes effect on the next edge; there is no partial update.
- FSM states:
  - SERVE: count refresh_ticks. Go to MOVE on the tick that brings the count to SERVE_FRAMES. Position is held.
  - MOVE: on refresh_tick with pause=0, update position. pause=1 goes to PAUSED.
  - PAUSED: position and direction are held. pause=0 returns to MOVE; the next tick moves normally.
  - pause has no effect in SERVE.
- Position update (MOVE, refresh_tick=1, pause=0), X axis:
  - dx=1: if ball_x+VEL >= H_MAX-16, then ball_x=H_MAX-16 and dx=0; else ball_x+=VEL.
  - dx=0: if ball_x <= VEL, then ball_x=0 and dx=1; else ball_x-=VEL.
  - The Y axis follows the same rules with V_MAX and dy.
  - Corner hit: both directions flip on the same tick.
  - Arithmetic is 11-bit internally, so there is no wrap.
  - The position is never outside [0, MAX-16].
- Pixel pipeline, stage 1 (registered):
  - in_box = video_on && x in [ball_x, ball_x+15] && y in [ball_y, ball_y+15].
  - rom_addr = (y-ball_y)[3:0] when in_box, else 0.
  - col = (x-ball_x)[3:0].
- Pixel pipeline, stage 2 (registered):
  - ball_on = in_box_q && rom_data[15-col_q].
  - ball_rgb = ball_on ? BALL_RGB : 0.
- Latency: ball_on is valid 2 clk after the corresponding x/y. The pixel mux delays sync signals by 2 to match.
- Position changes only on refresh_tick, which falls in vblank, so no frame shows a torn sprite.
- ball_x/ball_y are direct register outputs with zero latency.

Optional Feature:
BALL_BOUNCE_CNT_EN:
- Defined: adds output port bounce_cnt [7:0].
  - Increments by 1 on each refresh_tick in which at least one axis flips; a corner hit counts once.
  - Saturates at 255.
  - Cleared by reset.
- Undefined: the port and counter are absent; all other behaviour is identical.

Test Plan:
- Reset then 60 refresh_ticks -> ball_x=312, ball_y=232 throughout. On tick 61: ball_x=314, ball_y=234.
- Force ball_x=622, dx=1 (via run-in), then a tick -> ball_x=624, dx=0. Next tick -> ball_x=622.
- Scan x=312..327 on row y=232 with ball at (312,232) and a ROM model returning 16'h07E0 for row 0 -> ball_on high exactly for x=317..322, observed 2 clk later. ball_rgb=12'hF00 on those pixels, 0 elsewhere.
- pause=1 in MOVE for 5 ticks -> position unchanged. pause=0 -> next tick moves by VEL.
- Corner approach to (624,464) moving down-right -> both dx and dy flip on the same tick. With BALL_BOUNCE_CNT_EN, bounce_cnt increments by exactly 1.
- reset_n=0 for one clk mid-MOVE with video_on=1 over the ball -> next cycle ball_on=0, state SERVE, position back at centre.

Source files
------------

// File: rtl/ball_sprite_engine.sv
// Pong ball sprite: per-frame position/bounce update plus a two-stage pixel pipeline that reads the 16x16 ball ROM.
// Optional build macro BALL_BOUNCE_CNT_EN adds a saturating bounce counter output.
module ball_sprite_engine #(
    parameter int          H_MAX        = 640,
    parameter int          V_MAX        = 480,
    parameter int          VEL          = 2,
    parameter int          SERVE_FRAMES = 60,
    parameter logic [11:0] BALL_RGB     = 12'hF00
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [9:0]  x,
    input  logic [9:0]  y,
    input  logic        video_on,
    input  logic        refresh_tick,
    input  logic        pause,
    output logic [3:0]  rom_addr,
    input  logic [15:0] rom_data,
    output logic        ball_on,
    output logic [11:0] ball_rgb,
    output logic [9:0]  ball_x,
    output logic [9:0]  ball_y
`ifdef BALL_BOUNCE_CNT_EN
    ,
    output logic [7:0]  bounce_cnt
`endif
);

    localparam logic [10:0] VEL_W = 11'(VEL);
    localparam logic [9:0]  VEL_N = 10'(VEL);
    localparam int          SW    = (SERVE_FRAMES > 1) ? $clog2(SERVE_FRAMES + 1) : 1;

    typedef enum logic [1:0] {
        ST_SERVE,
        ST_MOVE,
        ST_PAUSED
    } state_t;

    state_t          r_state;
    logic [SW-1:0]   r_serve_cnt;
    logic [1:0][9:0] r_pos;          // index 0 is the X axis, 1 is the Y axis
    logic [1:0]      r_dir;          // 1 = increasing coordinate
    logic [1:0][9:0] w_pos_next;
    logic [1:0]      w_dir_next;
    logic [1:0]      w_flip;
    logic [1:0]      w_axis_in;
    logic [1:0][3:0] w_off;
    logic            w_in_box;
    logic            w_pix_on;

    logic            r_in_box;
    logic [3:0]      r_col;
    logic [3:0]      r_rom_addr;
    logic            r_ball_on;
    logic [11:0]     r_ball_rgb;
`ifdef BALL_BOUNCE_CNT_EN
    logic [7:0]      r_bounce_cnt;
`endif

    // Both axes share the same bounce rule and the same box test, only the limit differs.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_axis
            localparam logic [10:0] LIM = 11'((gi == 0) ? H_MAX - 16 : V_MAX - 16);
            logic [10:0] w_pos_ext;
            logic [10:0] w_coord_ext;
            logic [10:0] w_delta;
            logic [9:0]  w_step;
            logic        w_hit_hi;
            logic        w_hit_lo;

            assign w_pos_ext      = {1'b0, r_pos[gi]};
            assign w_coord_ext    = {1'b0, (gi == 0) ? x : y};
            assign w_hit_hi       = r_dir[gi] && (w_pos_ext + VEL_W >= LIM);
            assign w_hit_lo       = !r_dir[gi] && (w_pos_ext <= VEL_W);
            assign w_step         = r_dir[gi] ? r_pos[gi] + VEL_N : r_pos[gi] - VEL_N;
            assign w_pos_next[gi] = w_hit_hi ? LIM[9:0] : (w_hit_lo ? 10'd0 : w_step);
            assign w_dir_next[gi] = w_hit_hi ? 1'b0 : (w_hit_lo ? 1'b1 : r_dir[gi]);
            assign w_flip[gi]     = w_hit_hi | w_hit_lo;
            assign w_delta        = w_coord_ext - w_pos_ext;
            assign w_axis_in[gi]  = (w_coord_ext >= w_pos_ext) && (w_delta < 11'd16);
            assign w_off[gi]      = w_delta[3:0];
        end
    endgenerate

    assign w_in_box = video_on && (&w_axis_in);
    // ROM bit 15 is the leftmost pixel, so column c selects bit 15-c.
    assign w_pix_on = r_in_box && rom_data[~r_col];

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state     <= ST_SERVE;
            r_serve_cnt <= '0;
            r_pos[0]    <= 10'(H_MAX / 2 - 8);
            r_pos[1]    <= 10'(V_MAX / 2 - 8);
            r_dir       <= 2'b11;
`ifdef BALL_BOUNCE_CNT_EN
            r_bounce_cnt <= 8'd0;
`endif
        end else begin
            case (r_state)
                ST_SERVE: begin
                    if (refresh_tick) begin
                        r_serve_cnt <= r_serve_cnt + 1'b1;
                        if (r_serve_cnt == SW'(SERVE_FRAMES - 1)) begin
                            r_state <= ST_MOVE;
                        end
                    end
                end
                ST_MOVE: begin
                    if (pause) begin
                        r_state <= ST_PAUSED;
                    end else if (refresh_tick) begin
                        r_pos <= w_pos_next;
                        r_dir <= w_dir_next;
`ifdef BALL_BOUNCE_CNT_EN
                        if ((|w_flip) && (r_bounce_cnt != 8'hFF)) begin
                            r_bounce_cnt <= r_bounce_cnt + 8'd1;
                        end
`endif
                    end
                end
                ST_PAUSED: begin
                    if (!pause) begin
                        r_state <= ST_MOVE;
                    end
                end
                default: r_state <= ST_SERVE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_in_box   <= 1'b0;
            r_col      <= 4'd0;
            r_rom_addr <= 4'd0;
            r_ball_on  <= 1'b0;
            r_ball_rgb <= 12'h000;
        end else begin
            r_in_box   <= w_in_box;
            r_col      <= w_off[0];
            r_rom_addr <= w_in_box ? w_off[1] : 4'd0;
            r_ball_on  <= w_pix_on;
            r_ball_rgb <= w_pix_on ? BALL_RGB : 12'h000;
        end
    end

    assign rom_addr = r_rom_addr;
    assign ball_on  = r_ball_on;
    assign ball_rgb = r_ball_rgb;
    assign ball_x   = r_pos[0];
    assign ball_y   = r_pos[1];
`ifdef BALL_BOUNCE_CNT_EN
    assign bounce_cnt = r_bounce_cnt;
    // Flip flags are only consumed by the counter.
`else
    logic w_unused_flip;
    assign w_unused_flip = ^w_flip;
`endif

endmodule

// File: tb/tb_ball_sprite_engine.sv
// Self-checking bench for ball_sprite_engine: a default-size instance plus a small square-field instance
// (for an exact corner hit), both compared every cycle against a behavioural model.
module tb_ball_sprite_engine;

    localparam int NI = 2;
    localparam int HM [NI] = '{640, 64};
    localparam int VM [NI] = '{480, 64};
    localparam int SF [NI] = '{60, 4};
    localparam int VELC = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset_n, video_on, refresh_tick, pause;
    logic [9:0]  x, y;
    logic [15:0] rom_mem [16];

    logic [NI-1:0][3:0]  rom_addr;
    logic [NI-1:0][15:0] rom_data;
    logic [NI-1:0]       ball_on;
    logic [NI-1:0][11:0] ball_rgb;
    logic [NI-1:0][9:0]  ball_x, ball_y;
`ifdef BALL_BOUNCE_CNT_EN
    logic [NI-1:0][7:0]  bounce_cnt;
`endif

    assign rom_data[0] = rom_mem[rom_addr[0]];
    assign rom_data[1] = rom_mem[rom_addr[1]];

    ball_sprite_engine dut (
        .clk(clk), .reset_n(reset_n), .x(x), .y(y), .video_on(video_on),
        .refresh_tick(refresh_tick), .pause(pause), .rom_addr(rom_addr[0]),
        .rom_data(rom_data[0]), .ball_on(ball_on[0]), .ball_rgb(ball_rgb[0]),
        .ball_x(ball_x[0]), .ball_y(ball_y[0])
`ifdef BALL_BOUNCE_CNT_EN
        , .bounce_cnt(bounce_cnt[0])
`endif
    );

    ball_sprite_engine #(.H_MAX(64), .V_MAX(64), .SERVE_FRAMES(4)) dut_c (
        .clk(clk), .reset_n(reset_n), .x(x), .y(y), .video_on(video_on),
        .refresh_tick(refresh_tick), .pause(pause), .rom_addr(rom_addr[1]),
        .rom_data(rom_data[1]), .ball_on(ball_on[1]), .ball_rgb(ball_rgb[1]),
        .ball_x(ball_x[1]), .ball_y(ball_y[1])
`ifdef BALL_BOUNCE_CNT_EN
        , .bounce_cnt(bounce_cnt[1])
`endif
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input int inst, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s[%0d] got=%0d expected=%0d t=%0t", nm, inst, act, exp, $time);
        end
    endtask

    // Behavioural model: plain integers for position, direction, mode and the
    // two-cycle delay of the "lit pixel" answer.
    int mx [NI], my [NI], mdx [NI], mdy [NI];
    int mode [NI];          // 0 serving, 1 moving, 2 paused
    int served [NI];
    int mb [NI];
    int lit1 [NI], lit2 [NI], exp_addr [NI];
    bit model_ok = 1'b0;
    int m_row, m_col, nx, ny, ndx, ndy;
    bit m_in;

    function automatic void bounce(input int p, input int d, input int maxv,
                                   output int np, output int nd);
        int lim;
        lim = maxv - 16;
        if (d == 1) begin
            if (p + VELC >= lim) begin np = lim; nd = 0; end
            else begin np = p + VELC; nd = 1; end
        end else begin
            if (p <= VELC) begin np = 0; nd = 1; end
            else begin np = p - VELC; nd = 0; end
        end
    endfunction

    always @(posedge clk) begin
        for (int i = 0; i < NI; i++) begin
            if (!reset_n) begin
                mx[i] = HM[i] / 2 - 8;  my[i] = VM[i] / 2 - 8;
                mdx[i] = 1;  mdy[i] = 1;
                mode[i] = 0; served[i] = 0; mb[i] = 0;
                lit1[i] = 0; lit2[i] = 0; exp_addr[i] = 0;
            end else begin
                m_in = video_on && int'(x) >= mx[i] && int'(x) <= mx[i] + 15
                       && int'(y) >= my[i] && int'(y) <= my[i] + 15;
                m_row = int'(y) - my[i];
                m_col = int'(x) - mx[i];
                lit2[i] = lit1[i];
                lit1[i] = (m_in && rom_mem[m_row][15 - m_col]) ? 1 : 0;
                exp_addr[i] = m_in ? m_row : 0;
                if (mode[i] == 0) begin
                    if (refresh_tick) begin
                        served[i]++;
                        if (served[i] == SF[i]) mode[i] = 1;
                    end
                end else if (mode[i] == 1) begin
                    if (pause) mode[i] = 2;
                    else if (refresh_tick) begin
                        bounce(mx[i], mdx[i], HM[i], nx, ndx);
                        bounce(my[i], mdy[i], VM[i], ny, ndy);
                        if ((ndx != mdx[i] || ndy != mdy[i]) && mb[i] < 255) mb[i]++;
                        mx[i] = nx; my[i] = ny; mdx[i] = ndx; mdy[i] = ndy;
                    end
                end else begin
                    if (!pause) mode[i] = 1;
                end
            end
        end
        if (!reset_n) model_ok = 1'b1;
    end

    always @(negedge clk) begin
        if (model_ok) begin
            for (int i = 0; i < NI; i++) begin
                chk("ball_x", i, int'(ball_x[i]), mx[i]);
                chk("ball_y", i, int'(ball_y[i]), my[i]);
                chk("ball_on", i, int'(ball_on[i]), lit2[i]);
                chk("ball_rgb", i, int'(ball_rgb[i]), (lit2[i] != 0) ? 32'hF00 : 0);
                chk("rom_addr", i, int'(rom_addr[i]), exp_addr[i]);
`ifdef BALL_BOUNCE_CNT_EN
                chk("bounce_cnt", i, int'(bounce_cnt[i]), mb[i]);
`endif
            end
        end
    end

    task automatic pix_cycles(input int n);
        int k;
        repeat (n) begin
            @(negedge clk);
            refresh_tick = 1'b0;
            video_on = ($urandom_range(0, 7) != 0);
            k = int'($urandom_range(0, 2));
            if (k < NI) begin
                x = 10'(mx[k] + int'($urandom_range(0, 19)) - 2);
                y = 10'(my[k] + int'($urandom_range(0, 19)) - 2);
            end else begin
                x = 10'($urandom_range(0, 639));
                y = 10'($urandom_range(0, 479));
            end
        end
    endtask

    task automatic tick();
        pix_cycles(int'($urandom_range(2, 5)));
        @(negedge clk);
        refresh_tick = 1'b1;
        video_on = 1'b0;
        @(negedge clk);
        refresh_tick = 1'b0;
    endtask

    int lit_cnt, first_x, cb;

    initial begin
        reset_n = 1'b0; video_on = 1'b0; refresh_tick = 1'b0; pause = 1'b0;
        x = '0; y = '0;
        for (int r = 0; r < 16; r++) rom_mem[r] = 16'($urandom);
        rom_mem[0] = 16'h07E0;
        rom_mem[3] = 16'hFFFF;
        repeat (3) @(negedge clk);
        chk("reset_x", 0, int'(ball_x[0]), 312);
        chk("reset_y", 0, int'(ball_y[0]), 232);
        chk("reset_on", 0, int'(ball_on[0]), 0);
        chk("reset_addr", 0, int'(rom_addr[0]), 0);
        reset_n = 1'b1;

        // Scan row 0 of the centred ball; ball_on appears two clocks after each x.
        lit_cnt = 0; first_x = -1;
        for (int k = 0; k < 18; k++) begin
            @(negedge clk);
            if (ball_on[0]) begin
                lit_cnt++;
                if (first_x < 0) first_x = 312 + k - 2;
            end
            video_on = (k < 16);
            x = 10'(312 + k);
            y = 10'd232;
        end
        chk("scan_lit_count", 0, lit_cnt, 6);
        chk("scan_first_x", 0, first_x, 317);

        for (int t = 1; t <= 60; t++) begin
            tick();
            chk("serve_x", 0, int'(ball_x[0]), 312);
            chk("serve_y", 0, int'(ball_y[0]), 232);
            if (t == 15) begin
                chk("corner_pre_x", 1, int'(ball_x[1]), 46);
`ifdef BALL_BOUNCE_CNT_EN
                cb = int'(bounce_cnt[1]);
                chk("corner_pre_cnt", 1, cb, 0);
`endif
            end
            if (t == 16) begin
                chk("corner_x", 1, int'(ball_x[1]), 48);
                chk("corner_y", 1, int'(ball_y[1]), 48);
`ifdef BALL_BOUNCE_CNT_EN
                chk("corner_cnt", 1, int'(bounce_cnt[1]), 1);
`endif
            end
            if (t == 17) begin
                chk("corner_back_x", 1, int'(ball_x[1]), 46);
                chk("corner_back_y", 1, int'(ball_y[1]), 46);
            end
        end
        tick();
        chk("first_move_x", 0, int'(ball_x[0]), 314);
        chk("first_move_y", 0, int'(ball_y[0]), 234);

        for (int t = 2; t <= 157; t++) begin
            tick();
            if (t == 155) chk("runin_x", 0, int'(ball_x[0]), 622);
            if (t == 156) chk("right_wall_x", 0, int'(ball_x[0]), 624);
            if (t == 157) chk("right_back_x", 0, int'(ball_x[0]), 622);
        end

        @(negedge clk);
        pause = 1'b1;
        for (int t = 0; t < 5; t++) begin
            tick();
            chk("paused_x", 0, int'(ball_x[0]), 622);
        end
        @(negedge clk);
        pause = 1'b0;
        tick();
        chk("unpause_x", 0, int'(ball_x[0]), 620);

        for (int t = 0; t < 300; t++) begin
            @(negedge clk);
            pause = ($urandom_range(0, 5) == 0);
            tick();
        end
        @(negedge clk);
        pause = 1'b0;
        tick();

        // Park the scan on a fully lit ROM row, then reset mid-motion.
        @(negedge clk);
        video_on = 1'b1;
        x = 10'(mx[0] + 5);
        y = 10'(my[0] + 3);
        repeat (2) @(negedge clk);
        chk("pre_reset_on", 0, int'(ball_on[0]), 1);
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        chk("post_reset_on", 0, int'(ball_on[0]), 0);
        chk("post_reset_x", 0, int'(ball_x[0]), 312);
        chk("post_reset_y", 0, int'(ball_y[0]), 232);

        for (int t = 0; t < 70; t++) tick();
        chk("reserve_x", 0, int'(ball_x[0]), 312 + 2 * 10);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
